decode_issue_reg: RTL and testbench
===================================

DECODE_ISSUE_REG -- requirements
Module: decode_issue_reg

Interface
REQ-001 Parameter LOAD_USE_BUBBLES, default 1 (range 1..3): the number of bubble cycles inserted per load-use hazard.
REQ-002 Parameter PAYLOAD_W, default 96: the width of the opaque decoder payload (alu_ctl, immediate, branch fields, ll/sc/sw flags).
REQ-003 The clock is clk, input, 1 bit; reset is asynchronous and active-low, named rst_n.
REQ-004 Ports carrying the decoder result into the stage, all inputs:
- i_valid, 1 bit: decoder output valid.
- i_uses_rs 1 bit, i_rs_addr 5 bits: rs source use and address.
- i_uses_rt 1 bit, i_rt_addr 5 bits: rt source use and address.
- i_uses_rw 1 bit, i_rw_addr 5 bits: destination write use and address.
- i_is_mem_access 1 bit, i_mem_read 1 bit: memory access, and read (lw/ll) when i_mem_read=1.
- i_payload, PAYLOAD_W bits: passed through untouched.
REQ-005 Control inputs, 1 bit each:
- i_ex_stall: the execute stage cannot accept a new instruction.
- i_flush: a branch/jump redirect kills the younger instruction.
REQ-006 Outputs: o_valid 1, o_uses_rs 1, o_rs_addr 5, o_uses_rt 1, o_rt_addr 5, o_uses_rw 1, o_rw_addr 5, o_is_mem_access 1, o_mem_read 1, o_payload PAYLOAD_W; together these are the registered instruction presented to execute.
REQ-007 o_hold_fetch, output, 1 bit, combinational: tells fetch/decode to hold the current instruction.
REQ-008 o_bubble_count, output, 32 bits: saturating count of inserted load-use bubbles.

Function
REQ-009 Output registers SHALL update on the rising edge of clk; the latency from the decoder to the outputs SHALL be 1 cycle.
REQ-010 A hazard SHALL be detected when all of the following hold:
- o_valid & o_is_mem_access & o_mem_read & o_uses_rw;
- i_valid;
- (i_uses_rs & i_rs_addr==o_rw_addr) | (i_uses_rt & i_rt_addr==o_rw_addr).
REQ-011 The FSM SHALL have two states, RUN and BUBBLE, plus a 2-bit bubble counter.
REQ-012 In RUN with a hazard, no i_ex_stall and no i_flush:
- the FSM SHALL load the counter with LOAD_USE_BUBBLES-1;
- it SHALL register o_valid=0 while keeping the other output fields;
- it SHALL go to BUBBLE if LOAD_USE_BUBBLES>1, otherwise stay in RUN with the hazard cleared by the now-invalid output.
REQ-013 In BUBBLE, each unstalled cycle SHALL register o_valid=0 and decrement the counter; when the counter is 0, the FSM SHALL return to RUN and the held instruction SHALL issue on the following edge.
REQ-014 o_hold_fetch SHALL equal i_ex_stall | (hazard in RUN) | (state==BUBBLE), and SHALL be forced to 0 when i_flush=1.
REQ-015 With no hazard, no stall and no flush, all input fields SHALL be registered to the outputs.
REQ-016 i_ex_stall=1 without i_flush SHALL hold all outputs, the state and the counter unchanged.
REQ-017 Priority SHALL be rst_n > i_flush > i_ex_stall > hazard > normal issue.
REQ-018 i_flush=1 SHALL cause o_valid=0 next cycle and return the FSM to RUN with counter 0, even when i_ex_stall=1 or the FSM is in BUBBLE.
REQ-019 o_bubble_count SHALL increment by 1 on each edge that inserts a hazard bubble and is not flushed.
REQ-020 o_bubble_count SHALL saturate at 32'hFFFF_FFFF.
REQ-021 Bubbles caused by stalls or flushes SHALL NOT be counted in o_bubble_count.
REQ-022 An address match on register 0 SHALL never cause a hazard, because the decoder already clears the uses_* bits for register 0.

Reset
REQ-023 While rst_n=0, asynchronously:
- o_valid=0, all uses_* outputs=0, all address outputs=0;
- o_is_mem_access=0, o_mem_read=0, o_payload=0;
- state=RUN, counter=0, o_bubble_count=0.
REQ-024 o_hold_fetch SHALL evaluate to 0 during reset, since o_valid=0 and the state is RUN.
REQ-025 Reset asserted mid-bubble SHALL abandon the bubble, and the first instruction after reset SHALL issue normally.

Structure
REQ-026 The state enum (RUN, BUBBLE) and the LOAD_USE_BUBBLES default SHALL live in mips_core_pkg.
REQ-027 The hazard comparator SHALL be one combinational sub-module, load_use_detect, with inputs for the producer and consumer fields and a single hazard output.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- lw $t0 followed by add $t1,$t0,$t2 -> o_hold_fetch=1 for 1 cycle, o_valid=0 for one cycle, add issues the next cycle, o_bubble_count=1.
- LOAD_USE_BUBBLES=3 with the same pair -> three consecutive o_valid=0 cycles, o_bubble_count=3.
- lw $t0 followed by add $t1,$t2,$t3 (no dependency) -> no bubble, back-to-back issue.
- Hazard cycle with i_ex_stall=1 for 2 cycles -> outputs frozen for 2 cycles, then bubble, then add issues; count=1.
- i_flush during BUBBLE -> o_valid=0 next cycle, FSM in RUN, count unchanged.
- rst_n pulsed low mid-bubble -> all outputs zero immediately; o_bubble_count preloaded at 32'hFFFF_FFFF -> stays saturated after a further hazard.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared types and defaults for the MIPS core pipeline stages.
// Holds the issue-stage state encoding and the control fields that stage registers.
package mips_core_pkg;

    localparam int LOAD_USE_BUBBLES_DEFAULT = 1;
    localparam int PAYLOAD_W_DEFAULT        = 96;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } issue_state_e;

    // Decoded fields the issue register inspects; the opaque payload travels beside it.
    typedef struct packed {
        logic       valid;
        logic       uses_rs;
        logic [4:0] rs_addr;
        logic       uses_rt;
        logic [4:0] rt_addr;
        logic       uses_rw;
        logic [4:0] rw_addr;
        logic       is_mem_access;
        logic       mem_read;
    } issue_ctl_t;

endpackage

// File: rtl/decode_issue_reg_if.sv
// Decoder-to-execute issue bus: decoder result and pipeline controls in,
// registered instruction, fetch hold and bubble statistics out.
interface decode_issue_reg_if
    import mips_core_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEFAULT
);
    logic                 i_valid;
    logic                 i_uses_rs;
    logic [4:0]           i_rs_addr;
    logic                 i_uses_rt;
    logic [4:0]           i_rt_addr;
    logic                 i_uses_rw;
    logic [4:0]           i_rw_addr;
    logic                 i_is_mem_access;
    logic                 i_mem_read;
    logic [PAYLOAD_W-1:0] i_payload;
    logic                 i_ex_stall;
    logic                 i_flush;

    logic                 o_valid;
    logic                 o_uses_rs;
    logic [4:0]           o_rs_addr;
    logic                 o_uses_rt;
    logic [4:0]           o_rt_addr;
    logic                 o_uses_rw;
    logic [4:0]           o_rw_addr;
    logic                 o_is_mem_access;
    logic                 o_mem_read;
    logic [PAYLOAD_W-1:0] o_payload;
    logic                 o_hold_fetch;
    logic [31:0]          o_bubble_count;

    modport master (
        output i_valid, i_uses_rs, i_rs_addr, i_uses_rt, i_rt_addr,
               i_uses_rw, i_rw_addr, i_is_mem_access, i_mem_read, i_payload,
               i_ex_stall, i_flush,
        input  o_valid, o_uses_rs, o_rs_addr, o_uses_rt, o_rt_addr,
               o_uses_rw, o_rw_addr, o_is_mem_access, o_mem_read, o_payload,
               o_hold_fetch, o_bubble_count
    );

    modport slave (
        input  i_valid, i_uses_rs, i_rs_addr, i_uses_rt, i_rt_addr,
               i_uses_rw, i_rw_addr, i_is_mem_access, i_mem_read, i_payload,
               i_ex_stall, i_flush,
        output o_valid, o_uses_rs, o_rs_addr, o_uses_rt, o_rt_addr,
               o_uses_rw, o_rw_addr, o_is_mem_access, o_mem_read, o_payload,
               o_hold_fetch, o_bubble_count
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use comparator: flags a consumer that reads the register a pending load writes.
// Register 0 needs no special case because the decoder never marks it as used.
module load_use_detect (
    input  logic       prod_valid_i,
    input  logic       prod_is_mem_access_i,
    input  logic       prod_mem_read_i,
    input  logic       prod_uses_rw_i,
    input  logic [4:0] prod_rw_addr_i,
    input  logic       cons_valid_i,
    input  logic       cons_uses_rs_i,
    input  logic [4:0] cons_rs_addr_i,
    input  logic       cons_uses_rt_i,
    input  logic [4:0] cons_rt_addr_i,
    output logic       hazard_o
);

    logic prod_is_load;
    logic rs_match;
    logic rt_match;

    assign prod_is_load = prod_valid_i && prod_is_mem_access_i && prod_mem_read_i && prod_uses_rw_i;
    assign rs_match     = cons_uses_rs_i && (cons_rs_addr_i == prod_rw_addr_i);
    assign rt_match     = cons_uses_rt_i && (cons_rt_addr_i == prod_rw_addr_i);
    assign hazard_o     = prod_is_load && cons_valid_i && (rs_match || rt_match);

endmodule

// File: rtl/decode_issue_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, stall hold,
// flush kill and a saturating count of inserted load-use bubbles.
module decode_issue_reg
    import mips_core_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = LOAD_USE_BUBBLES_DEFAULT,
    parameter int PAYLOAD_W        = PAYLOAD_W_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    decode_issue_reg_if.slave bus
);

    localparam logic [1:0] BUBBLE_LOAD = 2'(LOAD_USE_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

    issue_state_e         state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    issue_ctl_t           ctl_q, ctl_d;
    issue_ctl_t           ctl_in;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [31:0]          bubble_cnt_q, bubble_cnt_d;
    logic                 hazard;
    logic                 bubble_inserted;

    assign ctl_in = '{
        valid:         bus.i_valid,
        uses_rs:       bus.i_uses_rs,
        rs_addr:       bus.i_rs_addr,
        uses_rt:       bus.i_uses_rt,
        rt_addr:       bus.i_rt_addr,
        uses_rw:       bus.i_uses_rw,
        rw_addr:       bus.i_rw_addr,
        is_mem_access: bus.i_is_mem_access,
        mem_read:      bus.i_mem_read
    };

    // The registered instruction is the producer; the decoder output is the consumer.
    load_use_detect u_load_use_detect (
        .prod_valid_i         (ctl_q.valid),
        .prod_is_mem_access_i (ctl_q.is_mem_access),
        .prod_mem_read_i      (ctl_q.mem_read),
        .prod_uses_rw_i       (ctl_q.uses_rw),
        .prod_rw_addr_i       (ctl_q.rw_addr),
        .cons_valid_i         (bus.i_valid),
        .cons_uses_rs_i       (bus.i_uses_rs),
        .cons_rs_addr_i       (bus.i_rs_addr),
        .cons_uses_rt_i       (bus.i_uses_rt),
        .cons_rt_addr_i       (bus.i_rt_addr),
        .hazard_o             (hazard)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        ctl_d           = ctl_q;
        payload_d       = payload_q;
        bubble_inserted = 1'b0;

        if (bus.i_flush) begin
            ctl_d.valid = 1'b0;
            state_d     = RUN;
            cnt_d       = 2'd0;
        end else if (!bus.i_ex_stall) begin
            unique case (state_q)
                RUN: begin
                    if (hazard) begin
                        // Bubble keeps the load's fields; only valid drops.
                        ctl_d.valid     = 1'b0;
                        cnt_d           = BUBBLE_LOAD;
                        state_d         = MULTI_BUBBLE ? BUBBLE : RUN;
                        bubble_inserted = 1'b1;
                    end else begin
                        ctl_d     = ctl_in;
                        payload_d = bus.i_payload;
                    end
                end
                BUBBLE: begin
                    ctl_d.valid     = 1'b0;
                    cnt_d           = cnt_q - 2'd1;
                    bubble_inserted = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
            endcase
        end

        bubble_cnt_d = (bubble_inserted && (bubble_cnt_q != 32'hFFFF_FFFF))
                     ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is cleared too so an idle stage presents all zeros.
            state_q      <= RUN;
            cnt_q        <= 2'd0;
            ctl_q        <= '0;
            payload_q    <= '0;
            bubble_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctl_q        <= ctl_d;
            payload_q    <= payload_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.o_hold_fetch = !bus.i_flush &&
                              (bus.i_ex_stall || (state_q == BUBBLE) || ((state_q == RUN) && hazard));

    assign bus.o_valid         = ctl_q.valid;
    assign bus.o_uses_rs       = ctl_q.uses_rs;
    assign bus.o_rs_addr       = ctl_q.rs_addr;
    assign bus.o_uses_rt       = ctl_q.uses_rt;
    assign bus.o_rt_addr       = ctl_q.rt_addr;
    assign bus.o_uses_rw       = ctl_q.uses_rw;
    assign bus.o_rw_addr       = ctl_q.rw_addr;
    assign bus.o_is_mem_access = ctl_q.is_mem_access;
    assign bus.o_mem_read      = ctl_q.mem_read;
    assign bus.o_payload       = payload_q;
    assign bus.o_bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_decode_issue_reg.sv
// Self-checking bench: single-bubble DUT driven from a vector table, three-bubble DUT
// exercised by hand-written bubble, flush, reset and saturation sequences.
module tb_decode_issue_reg;
    import mips_core_pkg::*;

    localparam int PW = 96;

    typedef struct packed {
        logic        valid;
        logic        uses_rs;
        logic [4:0]  rs;
        logic        uses_rt;
        logic [4:0]  rt;
        logic        uses_rw;
        logic [4:0]  rw;
        logic        mem;
        logic        rd;
        logic [31:0] pl;
    } instr_t;

    typedef struct packed {
        instr_t      ins;
        logic        stall;
        logic        flush;
        logic        exp_hold;
        logic        exp_valid;
        logic [4:0]  exp_rw;
        logic [31:0] exp_pl;
        logic [31:0] exp_bcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    decode_issue_reg_if #(.PAYLOAD_W(PW)) bus1 ();
    decode_issue_reg_if #(.PAYLOAD_W(PW)) bus3 ();

    decode_issue_reg #(.LOAD_USE_BUBBLES(1), .PAYLOAD_W(PW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    decode_issue_reg #(.LOAD_USE_BUBBLES(3), .PAYLOAD_W(PW)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic instr_t mk(input logic v, input logic urs, input logic [4:0] rs,
                                  input logic urt, input logic [4:0] rt, input logic urw,
                                  input logic [4:0] rw, input logic mem, input logic rd,
                                  input logic [31:0] pl);
        instr_t x;
        x = '{valid: v, uses_rs: urs, rs: rs, uses_rt: urt, rt: rt, uses_rw: urw,
              rw: rw, mem: mem, rd: rd, pl: pl};
        return x;
    endfunction

    function automatic vec_t vec(input instr_t ins, input logic st, input logic fl,
                                 input logic hold, input logic valid, input logic [4:0] rw,
                                 input logic [31:0] pl, input logic [31:0] bcnt);
        vec_t v;
        v = '{ins: ins, stall: st, flush: fl, exp_hold: hold, exp_valid: valid,
              exp_rw: rw, exp_pl: pl, exp_bcnt: bcnt};
        return v;
    endfunction

    task automatic drive1(input instr_t x, input logic st, input logic fl);
        bus1.i_valid = x.valid;   bus1.i_uses_rs = x.uses_rs; bus1.i_rs_addr = x.rs;
        bus1.i_uses_rt = x.uses_rt; bus1.i_rt_addr = x.rt;
        bus1.i_uses_rw = x.uses_rw; bus1.i_rw_addr = x.rw;
        bus1.i_is_mem_access = x.mem; bus1.i_mem_read = x.rd;
        bus1.i_payload = {64'd0, x.pl};
        bus1.i_ex_stall = st;     bus1.i_flush = fl;
    endtask

    task automatic drive3(input instr_t x, input logic st, input logic fl);
        bus3.i_valid = x.valid;   bus3.i_uses_rs = x.uses_rs; bus3.i_rs_addr = x.rs;
        bus3.i_uses_rt = x.uses_rt; bus3.i_rt_addr = x.rt;
        bus3.i_uses_rw = x.uses_rw; bus3.i_rw_addr = x.rw;
        bus3.i_is_mem_access = x.mem; bus3.i_mem_read = x.rd;
        bus3.i_payload = {64'd0, x.pl};
        bus3.i_ex_stall = st;     bus3.i_flush = fl;
    endtask

    // Clock edge then check the three-bubble DUT's registered outputs.
    task automatic edge3(input string tag, input logic valid, input logic [4:0] rw,
                         input logic [31:0] bcnt);
        @(posedge clk);
        #1;
        check({tag, " valid"}, 96'(bus3.o_valid), 96'(valid));
        check({tag, " rw"}, 96'(bus3.o_rw_addr), 96'(rw));
        check({tag, " bcnt"}, 96'(bus3.o_bubble_count), 96'(bcnt));
    endtask

    task automatic hold3(input string tag, input logic exp);
        #1;
        check({tag, " hold"}, 96'(bus3.o_hold_fetch), 96'(exp));
    endtask

    instr_t lw, add_dep, add_ind, add_nouse, add_rt, idle;
    vec_t   vecs[18];

    initial begin
        // $t0=8, $t1=9, $t2=10, $t3=11, $sp=29
        lw        = mk(1, 1, 29, 0, 0,  1, 8, 1, 1, 32'h100);
        add_dep   = mk(1, 1, 8,  1, 10, 1, 9, 0, 0, 32'h200);
        add_ind   = mk(1, 1, 10, 1, 11, 1, 9, 0, 0, 32'h300);
        add_nouse = mk(1, 0, 8,  0, 8,  1, 9, 0, 0, 32'h400);
        add_rt    = mk(1, 1, 10, 1, 8,  1, 9, 0, 0, 32'h500);
        idle      = '0;

        //              ins        st fl hold valid rw pl      bcnt
        vecs[0]  = vec(lw,        0, 0, 0,   1,    8, 32'h100, 0);
        vecs[1]  = vec(add_dep,   0, 0, 1,   0,    8, 32'h100, 1);
        vecs[2]  = vec(add_dep,   0, 0, 0,   1,    9, 32'h200, 1);
        vecs[3]  = vec(lw,        0, 0, 0,   1,    8, 32'h100, 1);
        vecs[4]  = vec(add_ind,   0, 0, 0,   1,    9, 32'h300, 1);
        vecs[5]  = vec(lw,        0, 0, 0,   1,    8, 32'h100, 1);
        vecs[6]  = vec(add_dep,   1, 0, 1,   1,    8, 32'h100, 1);
        vecs[7]  = vec(add_dep,   1, 0, 1,   1,    8, 32'h100, 1);
        vecs[8]  = vec(add_dep,   0, 0, 1,   0,    8, 32'h100, 2);
        vecs[9]  = vec(add_dep,   0, 0, 0,   1,    9, 32'h200, 2);
        vecs[10] = vec(lw,        0, 0, 0,   1,    8, 32'h100, 2);
        vecs[11] = vec(add_nouse, 0, 0, 0,   1,    9, 32'h400, 2);
        vecs[12] = vec(lw,        0, 0, 0,   1,    8, 32'h100, 2);
        vecs[13] = vec(add_dep,   1, 1, 0,   0,    8, 32'h100, 2);
        vecs[14] = vec(add_dep,   0, 0, 0,   1,    9, 32'h200, 2);
        vecs[15] = vec(lw,        0, 0, 0,   1,    8, 32'h100, 2);
        vecs[16] = vec(add_rt,    0, 0, 1,   0,    8, 32'h100, 3);
        vecs[17] = vec(add_rt,    0, 0, 0,   1,    9, 32'h500, 3);

        // Reset state
        drive1(idle, 0, 0);
        drive3(idle, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst valid", 96'(bus1.o_valid), 96'(0));
        check("rst rw", 96'(bus1.o_rw_addr), 96'(0));
        check("rst payload", bus1.o_payload, 96'(0));
        check("rst bcnt", 96'(bus1.o_bubble_count), 96'(0));
        check("rst hold", 96'(bus1.o_hold_fetch), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-bubble DUT: table-driven
        for (int i = 0; i < 18; i++) begin
            drive1(vecs[i].ins, vecs[i].stall, vecs[i].flush);
            #1;
            check($sformatf("v%0d hold", i), 96'(bus1.o_hold_fetch), 96'(vecs[i].exp_hold));
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), 96'(bus1.o_valid), 96'(vecs[i].exp_valid));
            check($sformatf("v%0d rw", i), 96'(bus1.o_rw_addr), 96'(vecs[i].exp_rw));
            check($sformatf("v%0d payload", i), bus1.o_payload, {64'd0, vecs[i].exp_pl});
            check($sformatf("v%0d bcnt", i), 96'(bus1.o_bubble_count), 96'(vecs[i].exp_bcnt));
        end

        // Three-bubble DUT: lw then dependent add
        drive3(lw, 0, 0);
        hold3("b3 lw", 0);
        edge3("b3 lw", 1, 8, 0);
        drive3(add_dep, 0, 0);
        hold3("b3 hz", 1);
        edge3("b3 bub1", 0, 8, 1);
        hold3("b3 bub1", 1);
        edge3("b3 bub2", 0, 8, 2);
        hold3("b3 bub2", 1);
        edge3("b3 bub3", 0, 8, 3);
        hold3("b3 bub3", 0);
        edge3("b3 add", 1, 9, 3);
        check("b3 add payload", bus3.o_payload, 96'h200);

        // Flush while in BUBBLE
        drive3(lw, 0, 0);
        edge3("fl lw", 1, 8, 3);
        drive3(add_dep, 0, 0);
        edge3("fl bub1", 0, 8, 4);
        drive3(add_dep, 0, 1);
        hold3("fl flush", 0);
        edge3("fl kill", 0, 8, 4);
        drive3(add_dep, 0, 0);
        hold3("fl run", 0);
        edge3("fl add", 1, 9, 4);

        // Reset asserted mid-bubble
        drive3(lw, 0, 0);
        edge3("rb lw", 1, 8, 4);
        drive3(add_dep, 0, 0);
        edge3("rb bub1", 0, 8, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb valid", 96'(bus3.o_valid), 96'(0));
        check("rb rw", 96'(bus3.o_rw_addr), 96'(0));
        check("rb uses_rs", 96'(bus3.o_uses_rs), 96'(0));
        check("rb mem_read", 96'(bus3.o_mem_read), 96'(0));
        check("rb payload", bus3.o_payload, 96'(0));
        check("rb bcnt", 96'(bus3.o_bubble_count), 96'(0));
        check("rb hold", 96'(bus3.o_hold_fetch), 96'(0));
        drive3(lw, 0, 0);
        #2;
        rst_n = 1'b1;
        edge3("rb first", 1, 8, 0);
        check("rb first payload", bus3.o_payload, 96'h100);

        // Saturation: preload the counter, then insert a further hazard
        #1;
        force dut3.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut3.bubble_cnt_q;
        #1;
        check("sat preload", 96'(bus3.o_bubble_count), 96'hFFFF_FFFF);
        drive3(add_dep, 0, 0);
        edge3("sat bub1", 0, 8, 32'hFFFF_FFFF);
        edge3("sat bub2", 0, 8, 32'hFFFF_FFFF);
        edge3("sat bub3", 0, 8, 32'hFFFF_FFFF);
        edge3("sat add", 1, 9, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
